receive_all: RTL and testbench

- Receiving end of the inter-board 4-phase Request/Ack link. Accepts six 6-bit words per message and returns Ack_out for each word.
- Reassembles the words into the GameControl message fields (msg_type, block_x, block_y, card, sel_len, move_dir). Presents them with a one-cycle valid pulse.
- Sits between the board-to-board pins and GameControl. Request_in and data are asynchronous to clk and are synchronized internally.

---
 rtl/receive_all.sv | 224 ++++++++++++++++++++++
 tb/tb_receive_all.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/receive_all.sv
`default_nettype none
// ============================================================================
// Module   : receive_all
// Purpose  : Receiving end of the inter-board 4-phase Request/Ack link.
//            Synchronizes Request_in and inter_data_in, acknowledges each
//            word, and reassembles six 6-bit words into the GameControl
//            message fields. A complete message produces a one-cycle
//            msg_valid pulse. A message left incomplete for TIMEOUT_CYCLES
//            idle cycles is dropped and reported with timeout_err.
// Options  : RECV_RST_DETECT_EN - when defined, 6'b111111 received as word0
//            is treated as an inter-board reset code and pulses
//            interboard_rst_out. Otherwise that output is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module receive_all #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       msg_valid,
  output logic [3:0] msg_type,
  output logic [4:0] block_x,
  output logic [2:0] block_y,
  output logic [5:0] card,
  output logic [2:0] sel_len,
  output logic       move_dir,
  output logic       recv_busy,
  output logic       timeout_err,
  output logic       interboard_rst_out
);

  // The idle counter only has to reach TIMEOUT_CYCLES-1; the expiring cycle
  // is recognised by comparing against that last value.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      c_last_word = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACK_HI = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]      r_req_sync;
  logic [SYNC_STAGES-1:0][5:0] r_data_sync;
  logic                        w_req_s;
  logic [5:0]                  w_data_s;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_ack_nxt;
  logic       w_sample;
  logic       w_rst_code;
  logic       w_to_run;

  logic       r_ack;
  logic [2:0] r_word_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic       r_msg_valid;
  logic       r_timeout_err;
  logic       r_irst;

  // Partial-message buffer: only the bits each field uses are kept.
  logic [3:0] r_w0;
  logic [4:0] r_w1;
  logic [2:0] r_w2;
  logic [5:0] r_w3;
  logic [2:0] r_w4;

  logic [3:0] r_msg_type;
  logic [4:0] r_block_x;
  logic [2:0] r_block_y;
  logic [5:0] r_card;
  logic [2:0] r_sel_len;
  logic       r_move_dir;

  // Synchronizer chains; both have the same depth so data and request age
  // together, and the SETTLE state adds one cycle of margin for the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_sync  <= '0;
      r_data_sync <= '0;
    end else begin
      r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], Request_in};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], inter_data_in};
    end
  end

  assign w_req_s  = r_req_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

`ifdef RECV_RST_DETECT_EN
  assign w_rst_code = (r_word_cnt == 3'd0) && (w_data_s == 6'h3F);
`else
  assign w_rst_code = 1'b0;
`endif

  // The idle counter runs only between words of a partially received message.
  assign w_to_run = (TIMEOUT_CYCLES != 0) && (r_state == S_IDLE) &&
                    (r_word_cnt != 3'd0) && !w_req_s;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake next state, sample strobe and next Ack level.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        if (w_req_s) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_req_s) begin
          w_sample    = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK_HI;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK_HI: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Word capture, message assembly, idle timeout and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack         <= 1'b0;
      r_word_cnt    <= 3'd0;
      r_to_cnt      <= '0;
      r_msg_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_irst        <= 1'b0;
      r_w0          <= '0;
      r_w1          <= '0;
      r_w2          <= '0;
      r_w3          <= '0;
      r_w4          <= '0;
      r_msg_type    <= '0;
      r_block_x     <= '0;
      r_block_y     <= '0;
      r_card        <= '0;
      r_sel_len     <= '0;
      r_move_dir    <= 1'b0;
    end else begin
      r_ack         <= w_ack_nxt;
      r_msg_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_irst        <= 1'b0;
      if (w_sample) begin
        r_to_cnt <= '0;
        if (w_rst_code) begin
          r_irst <= 1'b1;
        end else if (r_word_cnt == c_last_word) begin
          r_msg_type  <= r_w0;
          r_block_x   <= r_w1;
          r_block_y   <= r_w2;
          r_card      <= r_w3;
          r_sel_len   <= r_w4;
          r_move_dir  <= w_data_s[0];
          r_msg_valid <= 1'b1;
          r_word_cnt  <= 3'd0;
        end else begin
          case (r_word_cnt)
            3'd0:    r_w0 <= w_data_s[3:0];
            3'd1:    r_w1 <= w_data_s[4:0];
            3'd2:    r_w2 <= w_data_s[2:0];
            3'd3:    r_w3 <= w_data_s;
            default: r_w4 <= w_data_s[2:0];
          endcase
          r_word_cnt <= r_word_cnt + 3'd1;
        end
      end else if (w_to_run) begin
        if (r_to_cnt == c_to_last) begin
          r_to_cnt      <= '0;
          r_word_cnt    <= 3'd0;
          r_timeout_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign Ack_out            = r_ack;
  assign msg_valid          = r_msg_valid;
  assign msg_type           = r_msg_type;
  assign block_x            = r_block_x;
  assign block_y            = r_block_y;
  assign card               = r_card;
  assign sel_len            = r_sel_len;
  assign move_dir           = r_move_dir;
  assign recv_busy          = (r_word_cnt != 3'd0) || (r_state != S_IDLE);
  assign timeout_err        = r_timeout_err;
  assign interboard_rst_out = r_irst;

endmodule
`default_nettype wire

// File: tb/tb_receive_all.sv
`default_nettype none
// ============================================================================
// Module   : tb_receive_all
// Purpose  : Directed self-checking bench for receive_all. Build with
//            RECV_RST_DETECT_EN defined to exercise the reset-code path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receive_all;

  localparam int S  = 2;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = 6'd0;
  logic       Ack_out, msg_valid, move_dir, recv_busy, timeout_err, interboard_rst_out;
  logic [3:0] msg_type;
  logic [4:0] block_x;
  logic [2:0] block_y, sel_len;
  logic [5:0] card;
  logic [21:0] fields;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_to = 0;
  int n_irst = 0;

  receive_all #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .Request_in(Request_in), .inter_data_in(inter_data_in),
    .Ack_out(Ack_out), .msg_valid(msg_valid), .msg_type(msg_type), .block_x(block_x),
    .block_y(block_y), .card(card), .sel_len(sel_len), .move_dir(move_dir),
    .recv_busy(recv_busy), .timeout_err(timeout_err),
    .interboard_rst_out(interboard_rst_out)
  );

  always #5 clk = ~clk;

  assign fields = {msg_type, block_x, block_y, card, sel_len, move_dir};

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (msg_valid)          n_valid++;
    if (timeout_err)        n_to++;
    if (interboard_rst_out) n_irst++;
  end

  // One full 4-phase word. rise/fall are posedges from the request edge to
  // the Ack edge (50 means the bound expired).
  task automatic send_word(input logic [5:0] w, input int hold, output int rise,
                           output int fall, output logic v_rise, output int drops);
    @(negedge clk);
    inter_data_in = w;
    Request_in    = 1'b1;
    rise = 0;
    do begin
      @(posedge clk); rise++; @(negedge clk);
    end while (Ack_out !== 1'b1 && rise < 50);
    v_rise = msg_valid;
    drops  = 0;
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      if (Ack_out !== 1'b1) drops++;
    end
    Request_in = 1'b0;
    fall = 0;
    do begin
      @(posedge clk); fall++; @(negedge clk);
    end while (Ack_out !== 1'b0 && fall < 50);
  endtask

  task automatic send_msg(input logic [5:0] a, b, c, d, e, f,
                          output int bad, output logic [5:0] vm);
    logic [5:0] w [6];
    int r, fl, dr;
    logic v;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f;
    bad = 0;
    vm  = '0;
    for (int i = 0; i < 6; i++) begin
      send_word(w[i], 0, r, fl, v, dr);
      if (r != S + 2 || fl != S + 1) bad++;
      vm[i] = v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (Ack_out !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b want=0", Ack_out); end
    vectors++; if (msg_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", msg_valid); end
    vectors++; if (fields !== 22'd0) begin miscompares++; $display("FAIL reset_fields got=%h want=0", fields); end
    vectors++; if (recv_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", recv_busy); end
    vectors++; if ({timeout_err, interboard_rst_out} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses got=%b want=00", {timeout_err, interboard_rst_out}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int v0, bad; logic [5:0] vm;
    v0 = n_valid;
    send_msg(6'd3, 6'd17, 6'd5, 6'd42, 6'd6, 6'd1, bad, vm);
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL basic_latency bad_words=%0d want=0", bad); end
    vectors++; if (vm !== 6'b100000) begin miscompares++; $display("FAIL basic_valid_at_ack got=%b want=100000", vm); end
    vectors++; if (n_valid - v0 != 1) begin miscompares++; $display("FAIL basic_valid_count got=%0d want=1", n_valid - v0); end
    vectors++; if (fields !== {4'd3, 5'd17, 3'd5, 6'd42, 3'd6, 1'b1}) begin miscompares++;
      $display("FAIL basic_fields got=%h want=%h", fields, {4'd3, 5'd17, 3'd5, 6'd42, 3'd6, 1'b1}); end
    vectors++; if (recv_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy got=%b want=0", recv_busy); end
  endtask

  task automatic test_timeout();
    int v0, t0, k, bad, r, fl, dr; logic v; logic [5:0] vm;
    v0 = n_valid; t0 = n_to;
    send_word(6'd1, 0, r, fl, v, dr);
    send_word(6'd2, 0, r, fl, v, dr);
    send_word(6'd3, 0, r, fl, v, dr);
    vectors++; if (recv_busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_partial got=%b want=1", recv_busy); end
    k = 0;
    do begin
      @(posedge clk); k++; @(negedge clk);
    end while (timeout_err !== 1'b1 && k < 200);
    vectors++; if (k != TO) begin miscompares++; $display("FAIL to_delay got=%0d want=%0d", k, TO); end
    vectors++; if (recv_busy !== 1'b0) begin miscompares++; $display("FAIL to_busy_after got=%b want=0", recv_busy); end
    @(posedge clk); @(negedge clk);
    vectors++; if (n_to - t0 != 1) begin miscompares++; $display("FAIL to_pulse_count got=%0d want=1", n_to - t0); end
    vectors++; if (fields !== {4'd3, 5'd17, 3'd5, 6'd42, 3'd6, 1'b1} || n_valid != v0) begin miscompares++;
      $display("FAIL to_fields_held got=%h valids=%0d want=%h valids=0", fields, n_valid - v0, {4'd3, 5'd17, 3'd5, 6'd42, 3'd6, 1'b1}); end
    send_msg(6'd9, 6'd10, 6'd4, 6'd20, 6'd2, 6'd0, bad, vm);
    vectors++; if (fields !== {4'd9, 5'd10, 3'd4, 6'd20, 3'd2, 1'b0} || vm !== 6'b100000) begin miscompares++;
      $display("FAIL to_fresh_msg got=%h vm=%b want=%h vm=100000", fields, vm, {4'd9, 5'd10, 3'd4, 6'd20, 3'd2, 1'b0}); end
  endtask

  task automatic test_all_ones();
    int v0, bad; logic [5:0] vm;
    v0 = n_valid;
    send_msg(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, bad, vm);
    vectors++; if (n_valid - v0 != 1) begin miscompares++; $display("FAIL ones_valid_count got=%0d want=1", n_valid - v0); end
    vectors++; if (fields !== {4'hF, 5'h1F, 3'h7, 6'h3F, 3'h7, 1'b1}) begin miscompares++;
      $display("FAIL ones_fields got=%h want=%h", fields, {4'hF, 5'h1F, 3'h7, 6'h3F, 3'h7, 1'b1}); end
  endtask

  task automatic test_long_hold();
    int v0, r, fl, dr; logic v;
    v0 = n_valid;
    send_word(6'd7, 20, r, fl, v, dr);
    vectors++; if (r != S + 2) begin miscompares++; $display("FAIL hold_rise got=%0d want=%0d", r, S + 2); end
    vectors++; if (dr != 0) begin miscompares++; $display("FAIL hold_ack_drops got=%0d want=0", dr); end
    vectors++; if (fl != S + 1) begin miscompares++; $display("FAIL hold_fall got=%0d want=%0d", fl, S + 1); end
    send_word(6'd8, 0, r, fl, v, dr);
    send_word(6'd1, 0, r, fl, v, dr);
    send_word(6'd2, 0, r, fl, v, dr);
    send_word(6'd3, 0, r, fl, v, dr);
    send_word(6'd0, 0, r, fl, v, dr);
    vectors++; if (fields !== {4'd7, 5'd8, 3'd1, 6'd2, 3'd3, 1'b0} || n_valid - v0 != 1) begin miscompares++;
      $display("FAIL hold_no_double_sample got=%h valids=%0d want=%h valids=1", fields, n_valid - v0, {4'd7, 5'd8, 3'd1, 6'd2, 3'd3, 1'b0}); end
  endtask

  task automatic test_reset_mid();
    int v0, k, r, fl, dr; logic v;
    send_word(6'd1, 0, r, fl, v, dr);
    send_word(6'd2, 0, r, fl, v, dr);
    send_word(6'd3, 0, r, fl, v, dr);
    send_word(6'd4, 0, r, fl, v, dr);
    @(negedge clk);
    inter_data_in = 6'd11;
    Request_in    = 1'b1;
    k = 0;
    do begin
      @(posedge clk); k++; @(negedge clk);
    end while (Ack_out !== 1'b1 && k < 50);
    vectors++; if (Ack_out !== 1'b1) begin miscompares++; $display("FAIL rmid_ack_hi got=%b want=1", Ack_out); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++; if (Ack_out !== 1'b0) begin miscompares++; $display("FAIL rmid_ack got=%b want=0", Ack_out); end
    vectors++; if (recv_busy !== 1'b0 || fields !== 22'd0) begin miscompares++;
      $display("FAIL rmid_cleared got busy=%b fields=%h want busy=0 fields=0", recv_busy, fields); end
    rst = 1'b0;
    v0  = n_valid;
    // Request_in is still high: the same word must arrive as word0.
    k = 0;
    do begin
      @(posedge clk); k++; @(negedge clk);
    end while (Ack_out !== 1'b1 && k < 50);
    vectors++; if (k != S + 2) begin miscompares++; $display("FAIL rmid_rereceive got=%0d want=%0d", k, S + 2); end
    Request_in = 1'b0;
    k = 0;
    do begin
      @(posedge clk); k++; @(negedge clk);
    end while (Ack_out !== 1'b0 && k < 50);
    send_word(6'd12, 0, r, fl, v, dr);
    send_word(6'd3, 0, r, fl, v, dr);
    send_word(6'd44, 0, r, fl, v, dr);
    send_word(6'd5, 0, r, fl, v, dr);
    send_word(6'd1, 0, r, fl, v, dr);
    vectors++; if (fields !== {4'd11, 5'd12, 3'd3, 6'd44, 3'd5, 1'b1} || n_valid - v0 != 1) begin miscompares++;
      $display("FAIL rmid_next_msg got=%h valids=%0d want=%h valids=1", fields, n_valid - v0, {4'd11, 5'd12, 3'd3, 6'd44, 3'd5, 1'b1}); end
  endtask

`ifdef RECV_RST_DETECT_EN
  task automatic test_rst_code();
    int v0, i0, bad, r, fl, dr; logic v; logic [5:0] vm;
    v0 = n_valid; i0 = n_irst;
    send_word(6'h3F, 0, r, fl, v, dr);
    vectors++; if (r != S + 2 || fl != S + 1) begin miscompares++; $display("FAIL code_handshake got rise=%0d fall=%0d want %0d/%0d", r, fl, S + 2, S + 1); end
    vectors++; if (n_irst - i0 != 1) begin miscompares++; $display("FAIL code_irst_count got=%0d want=1", n_irst - i0); end
    vectors++; if (n_valid != v0 || recv_busy !== 1'b0) begin miscompares++;
      $display("FAIL code_no_msg got valids=%0d busy=%b want 0/0", n_valid - v0, recv_busy); end
    send_msg(6'd5, 6'd6, 6'd7, 6'd8, 6'd1, 6'd0, bad, vm);
    vectors++; if (fields !== {4'd5, 5'd6, 3'd7, 6'd8, 3'd1, 1'b0} || n_valid - v0 != 1) begin miscompares++;
      $display("FAIL code_next_msg got=%h valids=%0d want=%h valids=1", fields, n_valid - v0, {4'd5, 5'd6, 3'd7, 6'd8, 3'd1, 1'b0}); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_long_hold();
    test_reset_mid();
`ifdef RECV_RST_DETECT_EN
    test_rst_code();
`else
    test_all_ones();
    vectors++; if (n_irst != 0) begin miscompares++; $display("FAIL irst_tied_low got=%0d want=0", n_irst); end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
